// File: rtl/n64_joybus_rx.sv
// N64 joybus receive decoder: pulse-width bit slicer with MSB-first byte assembly and idle framing.
// Build option N64_RX_GLITCH_FILTER_EN inserts a 3-sample majority filter after the synchroniser.
module n64_joybus_rx #(
  parameter int CLKS_PER_US = 50,
  parameter int IDLE_US     = 5,
  parameter int MAX_LOW_US  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic [5:0] byte_count,
  output logic       frame_done,
  output logic       frame_error,
  output logic       busy
);

  localparam logic [15:0] T_BIT  = 16'(2 * CLKS_PER_US);
  localparam logic [15:0] T_IDLE = 16'(IDLE_US * CLKS_PER_US);
  localparam logic [15:0] T_MAX  = 16'(MAX_LOW_US * CLKS_PER_US);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOW     = 2'd1;
  localparam logic [1:0] S_HIGH    = 2'd2;
  localparam logic [1:0] S_WAIT_HI = 2'd3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  logic sync1_q, ds_q, ds_d_q, ds_f;
  logic [2:0] flush_q;
  logic armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      ds_q    <= 1'b1;
    end else begin
      sync1_q <= data;
      ds_q    <= sync1_q;
    end
  end

`ifdef N64_RX_GLITCH_FILTER_EN
  localparam logic [2:0] FLUSH = 3'd5;
  logic m0_q, m1_q, filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_q   <= 1'b1;
      m1_q   <= 1'b1;
      filt_q <= 1'b1;
    end else begin
      m0_q   <= ds_q;
      m1_q   <= m0_q;
      filt_q <= (ds_q & m0_q) | (ds_q & m1_q) | (m0_q & m1_q);
    end
  end

  assign ds_f = filt_q;
`else
  localparam logic [2:0] FLUSH = 3'd2;
  assign ds_f = ds_q;
`endif

  logic fall, rise;
  assign fall = ds_d_q & ~ds_f;
  assign rise = ~ds_d_q & ds_f;

  // A frame may only start once the line has been observed high with real (post-flush) samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ds_d_q  <= 1'b1;
      flush_q <= 3'd0;
      armed_q <= 1'b0;
    end else begin
      ds_d_q  <= ds_f;
      flush_q <= (flush_q == FLUSH) ? flush_q : flush_q + 3'd1;
      armed_q <= armed_q | ((flush_q == FLUSH) & ds_f);
    end
  end

  logic [1:0]  state_q, state_d;
  logic [15:0] low_cnt_q, low_cnt_d, high_cnt_q, high_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d, byte_out_q, byte_out_d;
  logic [5:0]  byte_count_q, byte_count_d;
  logic        byte_valid_q, byte_valid_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_error_q, frame_error_d;
  logic        rx_bit;

  always_comb begin
    state_d       = state_q;
    low_cnt_d     = low_cnt_q;
    high_cnt_d    = high_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    byte_out_d    = byte_out_q;
    byte_count_d  = byte_count_q;
    byte_valid_d  = 1'b0;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
    rx_bit        = 1'b0;
    case (state_q)
      S_IDLE: begin
        bit_cnt_d    = 3'd0;
        byte_count_d = 6'd0;
        low_cnt_d    = 16'd0;
        high_cnt_d   = 16'd0;
        if (fall && armed_q) begin
          state_d   = S_LOW;
          low_cnt_d = 16'd1;
        end
      end
      S_LOW: begin
        if (rise) begin
          rx_bit     = (low_cnt_q < T_BIT);
          shreg_d    = {shreg_q[6:0], rx_bit};
          high_cnt_d = 16'd1;
          state_d    = S_HIGH;
          if (bit_cnt_q == 3'd7) begin
            byte_out_d   = {shreg_q[6:0], rx_bit};
            byte_valid_d = 1'b1;
            byte_count_d = sat_inc6(byte_count_q);
            bit_cnt_d    = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (low_cnt_q >= T_MAX) begin
          frame_error_d = 1'b1;
          high_cnt_d    = 16'd0;
          state_d       = S_WAIT_HI;
        end else begin
          low_cnt_d = sat_inc16(low_cnt_q);
        end
      end
      S_HIGH: begin
        // Idle timeout beats a coincident fall; the stop bit leaves exactly one pending bit.
        if (high_cnt_q >= T_IDLE) begin
          state_d = S_IDLE;
          if (bit_cnt_q == 3'd1 && byte_count_q != 6'd0) frame_done_d  = 1'b1;
          else                                           frame_error_d = 1'b1;
        end else if (fall) begin
          state_d   = S_LOW;
          low_cnt_d = 16'd1;
        end else begin
          high_cnt_d = sat_inc16(high_cnt_q);
        end
      end
      default: begin
        if (high_cnt_q >= T_IDLE) state_d = S_IDLE;
        else if (!ds_f)           high_cnt_d = 16'd0;
        else                      high_cnt_d = sat_inc16(high_cnt_q);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      low_cnt_q     <= 16'd0;
      high_cnt_q    <= 16'd0;
      bit_cnt_q     <= 3'd0;
      shreg_q       <= 8'd0;
      byte_out_q    <= 8'd0;
      byte_count_q  <= 6'd0;
      byte_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      low_cnt_q     <= low_cnt_d;
      high_cnt_q    <= high_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      byte_out_q    <= byte_out_d;
      byte_count_q  <= byte_count_d;
      byte_valid_q  <= byte_valid_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign byte_out    = byte_out_q;
  assign byte_valid  = byte_valid_q;
  assign byte_count  = byte_count_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_n64_joybus_rx.sv
// Bench for n64_joybus_rx: table-driven frames, directed timing/reset/error sequences, random frames vs. a pulse-width model.
module tb_n64_joybus_rx;

  localparam int T_BIT  = 100;
  localparam int T_IDLE = 250;
  localparam int T_MAX  = 250;
`ifdef N64_RX_GLITCH_FILTER_EN
  localparam int LAT        = 5;
  localparam int GLITCH_ERR = 0;
`else
  localparam int LAT        = 3;
  localparam int GLITCH_ERR = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data = 1'b1;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic [5:0] byte_count;
  logic       frame_done;
  logic       frame_error;
  logic       busy;

  always #10 clk = ~clk;

  n64_joybus_rx dut (
    .clk(clk), .rst_n(rst_n), .data(data),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_count(byte_count),
    .frame_done(frame_done), .frame_error(frame_error), .busy(busy)
  );

  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string nm, input int act, input int exp);
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor collects every strobe on the falling edge.
  logic [7:0] mon_bytes[$];
  int mon_done = 0, mon_err = 0, mon_cnt_end = 0;
  always @(negedge clk) begin
    if (byte_valid) mon_bytes.push_back(byte_out);
    if (frame_done) begin mon_done++; mon_cnt_end = byte_count; end
    if (frame_error) begin mon_err++; mon_cnt_end = byte_count; end
  end

  int b_bytes, b_done, b_err;
  task automatic snap();
    b_bytes = mon_bytes.size();
    b_done  = mon_done;
    b_err   = mon_err;
  endtask

  int lows_q[$];
  int highs_q[$];
  logic [7:0] exp_q[$];

  task automatic add_pulse(input int lo, input int hi);
    lows_q.push_back(lo);
    highs_q.push_back(hi);
  endtask

  task automatic add_bit(input bit b);
    if (b) add_pulse(50, 150);
    else   add_pulse(150, 50);
  endtask

  task automatic play_frame(input int tail);
    for (int i = 0; i < lows_q.size(); i++) begin
      data = 1'b0;
      repeat (lows_q[i]) @(negedge clk);
      data = 1'b1;
      repeat (highs_q[i]) @(negedge clk);
    end
    repeat (tail) @(negedge clk);
  endtask

  // Reference: each low pulse is one bit (short = 1), bits pack MSB-first, the stop bit leaves one over.
  task automatic model_frame(output bit edone, output int ecnt);
    int val, nbits, nb;
    exp_q.delete();
    val   = 0;
    nbits = lows_q.size();
    for (int i = 0; i < nbits; i++) begin
      val = val * 2 + ((lows_q[i] < T_BIT) ? 1 : 0);
      if (i % 8 == 7) begin
        exp_q.push_back(8'(val % 256));
        val = 0;
      end
    end
    nb    = nbits / 8;
    edone = (nbits % 8 == 1) && (nb >= 1);
    ecnt  = (nb > 63) ? 63 : nb;
  endtask

  task automatic check_frame(input string nm, input bit edone, input int ecnt);
    check({nm, ".nbytes"}, mon_bytes.size() - b_bytes, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (b_bytes + i < mon_bytes.size())
        check({nm, ".byte"}, int'(mon_bytes[b_bytes + i]), int'(exp_q[i]));
    check({nm, ".done"}, mon_done - b_done, edone ? 1 : 0);
    check({nm, ".err"}, mon_err - b_err, edone ? 0 : 1);
    check({nm, ".count"}, mon_cnt_end, ecnt);
  endtask

  typedef struct {
    logic [23:0] bits;
    int          nbits;
    bit          stop;
    int          ebytes;
    logic [23:0] eb;
    bit          edone;
    int          ecnt;
  } vec_t;

  vec_t vt[6];

  task automatic send_byte_frame(input logic [7:0] b, input int tail);
    logic [7:0] v;
    v = b;
    lows_q.delete(); highs_q.delete();
    for (int i = 7; i >= 0; i--) add_bit(v[i]);
    add_bit(1'b1);
    play_frame(tail);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit edone;
    int ecnt;

    vt[0] = '{24'h010000, 8,  1'b1, 1, 24'h010000, 1'b1, 1};
    vt[1] = '{24'h050002, 24, 1'b1, 3, 24'h050002, 1'b1, 3};
    vt[2] = '{24'hA5C000, 13, 1'b0, 1, 24'hA50000, 1'b0, 1};
    vt[3] = '{24'hFF0000, 8,  1'b0, 1, 24'hFF0000, 1'b0, 1};
    vt[4] = '{24'h000000, 0,  1'b1, 0, 24'h000000, 1'b0, 0};
    vt[5] = '{24'h3CA500, 16, 1'b1, 2, 24'h3CA500, 1'b1, 2};

    // Reset, then line idle for 20 us
    repeat (3) @(negedge clk);
    check("reset.busy", busy, 0);
    check("reset.byte_out", byte_out, 0);
    check("reset.byte_count", byte_count, 0);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    check("idle.strobes", mon_bytes.size() + mon_done + mon_err, 0);
    check("idle.busy", busy, 0);
    check("idle.byte_out", byte_out, 0);

    // Console status command with exact strobe timing
    snap();
    lows_q.delete(); highs_q.delete();
    for (int i = 0; i < 7; i++) add_bit(1'b0);
    play_frame(0);
    data = 1'b0;
    repeat (50) @(negedge clk);
    data = 1'b1;
    n = 0;
    while (!byte_valid && n < 20) begin @(negedge clk); n++; end
    check("status.bv_latency", n, LAT);
    check("status.byte_out", byte_out, 8'h01);
    check("status.byte_count", byte_count, 1);
    repeat (150 - n) @(negedge clk);
    data = 1'b0;
    repeat (50) @(negedge clk);
    data = 1'b1;
    n = 0;
    while (!frame_done && !frame_error && n < 400) begin @(negedge clk); n++; end
    check("status.done_latency", n, LAT + T_IDLE);
    check("status.frame_done", frame_done, 1);
    check("status.frame_error", frame_error, 0);
    repeat (60) @(negedge clk);
    exp_q.delete(); exp_q.push_back(8'h01);
    check_frame("status", 1'b1, 1);

    // Table of whole frames
    for (int k = 0; k < 6; k++) begin
      snap();
      lows_q.delete(); highs_q.delete();
      for (int i = 0; i < vt[k].nbits; i++) add_bit(vt[k].bits[23 - i]);
      if (vt[k].stop) add_bit(1'b1);
      play_frame(300);
      exp_q.delete();
      for (int j = 0; j < vt[k].ebytes; j++) exp_q.push_back(vt[k].eb[23 - 8 * j -: 8]);
      check_frame($sformatf("vec%0d", k), vt[k].edone, vt[k].ecnt);
      check($sformatf("vec%0d.busy", k), busy, 0);
    end

    // Bit threshold boundary: 99-cycle low is a 1, 100-cycle low is a 0
    snap();
    lows_q.delete(); highs_q.delete();
    for (int i = 0; i < 4; i++) begin add_pulse(99, 60); add_pulse(100, 60); end
    add_pulse(50, 60);
    play_frame(300);
    exp_q.delete(); exp_q.push_back(8'hAA);
    check_frame("threshold", 1'b1, 1);

    // Line stuck low mid-frame
    snap();
    lows_q.delete(); highs_q.delete();
    for (int i = 7; i >= 0; i--) add_bit(((8'h05 >> i) & 1) != 0);
    play_frame(0);
    data = 1'b0;
    n = 0;
    while (!frame_error && n < 500) begin @(negedge clk); n++; end
    check("stuck.err_latency", n, LAT + T_MAX);
    repeat (400 - n) @(negedge clk);
    check("stuck.busy_low", busy, 1);
    data = 1'b1;
    repeat (150) @(negedge clk);
    data = 1'b0;
    repeat (50) @(negedge clk);
    data = 1'b1;
    repeat (150) @(negedge clk);
    check("stuck.busy_waiting", busy, 1);
    repeat (250) @(negedge clk);
    check("stuck.busy_after", busy, 0);
    exp_q.delete(); exp_q.push_back(8'h05);
    check_frame("stuck", 1'b0, 1);
    snap();
    send_byte_frame(8'h01, 300);
    exp_q.delete(); exp_q.push_back(8'h01);
    check_frame("stuck.next", 1'b1, 1);

    // Reset pulse during the low phase of bit 4
    lows_q.delete(); highs_q.delete();
    for (int i = 0; i < 3; i++) add_bit(1'b1);
    play_frame(0);
    data = 1'b0;
    repeat (75) @(negedge clk);
    check("midrst.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst.byte_out", byte_out, 0);
    check("midrst.busy", busy, 0);
    check("midrst.byte_count", byte_count, 0);
    snap();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (72) @(negedge clk);
    data = 1'b1;
    repeat (600) @(negedge clk);
    check("midrst.strobes", (mon_bytes.size() - b_bytes) + (mon_done - b_done) + (mon_err - b_err), 0);
    check("midrst.busy_after", busy, 0);
    snap();
    send_byte_frame(8'h01, 300);
    exp_q.delete(); exp_q.push_back(8'h01);
    check_frame("midrst.next", 1'b1, 1);

    // Single-cycle low glitch between frames
    snap();
    data = 1'b0;
    @(negedge clk);
    data = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch.err", mon_err - b_err, GLITCH_ERR);
    check("glitch.done", mon_done - b_done, 0);
    check("glitch.bytes", mon_bytes.size() - b_bytes, 0);

    // byte_count saturation with fast pulses
    snap();
    lows_q.delete(); highs_q.delete();
    for (int i = 0; i < 64 * 8; i++) add_pulse(5, 5);
    add_pulse(5, 5);
    play_frame(300);
    model_frame(edone, ecnt);
    check("sat.model_count", ecnt, 63);
    check_frame("sat", edone, ecnt);

    // Random frames against the model
    for (int f = 0; f < 6; f++) begin
      int nb;
      snap();
      lows_q.delete(); highs_q.delete();
      nb = $urandom_range(1, 18);
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 1) == 1) add_pulse($urandom_range(10, 99), $urandom_range(10, 80));
        else                           add_pulse($urandom_range(100, 160), $urandom_range(10, 80));
      end
      if ($urandom_range(0, 3) != 0) add_pulse($urandom_range(10, 99), $urandom_range(10, 80));
      play_frame(300);
      model_frame(edone, ecnt);
      check_frame($sformatf("rand%0d", f), edone, ecnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
